// File: rtl/instr_mem_loadable_if.sv
// Fetch and program-load signal bundle for instr_mem_loadable.
// master = core/loader side, slave = memory side.
interface instr_mem_loadable_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16
);
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_pc;
  logic              fetch_ready;
  logic              stall;
  logic              instr_valid;
  logic [DATA_W-1:0] instr;
  logic              addr_err;
  logic              load_start;
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_busy;
  logic              load_done;

  modport master (
    output fetch_req, fetch_pc, stall, load_start, load_valid, load_data,
    input  fetch_ready, instr_valid, instr, addr_err, load_busy, load_done
  );

  modport slave (
    input  fetch_req, fetch_pc, stall, load_start, load_valid, load_data,
    output fetch_ready, instr_valid, instr, addr_err, load_busy, load_done
  );
endinterface

// File: rtl/instr_mem_loadable.sv
// Instruction memory with registered byte-addressed fetch, stall hold and a
// serial program-load port that fills the array from word 0.
module instr_mem_loadable #(
  parameter int unsigned       DATA_W   = 16,
  parameter int unsigned       ADDR_W   = 16,
  parameter int unsigned       DEPTH    = 16,
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input logic                  clk,
  input logic                  rst,
  instr_mem_loadable_if.slave  bus
);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic {RUN, LOAD} state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic fetch_ready;
  logic accept;
  logic we;
  logic oor;

  // Any set PC bit above the word-index field means the fetch is past the array.
  if (IDX_W + 1 < ADDR_W) begin : g_oor
    assign oor = |bus.fetch_pc[ADDR_W-1:IDX_W+1];
  end else begin : g_full
    assign oor = 1'b0;
  end

  assign fetch_ready = (state_q == RUN) && !bus.stall;
  assign accept      = bus.fetch_req && fetch_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    we      = 1'b0;
    case (state_q)
      RUN: begin
        if (bus.load_start) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        if (bus.load_valid) begin
          we = 1'b1;
          if (cnt_q == LAST_IDX) begin
            state_d = RUN;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    err_d   = err_q;
    instr_d = instr_q;
    if (!bus.stall) begin
      if (accept) begin
        valid_d = 1'b1;
        if (bus.fetch_pc[0] || oor) begin
          err_d   = 1'b1;
          instr_d = NOP_WORD;
        end else begin
          err_d   = 1'b0;
          instr_d = mem_q[bus.fetch_pc[IDX_W:1]];
        end
      end else begin
        valid_d = 1'b0;
        err_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      instr_q <= NOP_WORD;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      instr_q <= instr_d;
    end
  end

  // Array is deliberately left out of reset so a loaded program survives it.
  always_ff @(posedge clk) begin
    if (!rst && we) begin
      mem_q[cnt_q] <= bus.load_data;
    end
  end

  assign bus.fetch_ready = fetch_ready;
  assign bus.instr_valid = valid_q;
  assign bus.instr       = instr_q;
  assign bus.addr_err    = err_q;
  assign bus.load_busy   = (state_q == LOAD);
  assign bus.load_done   = done_q;
endmodule

// File: doc/instr_mem_loadable.md
Name: instr_mem_loadable

Overview:
- Parametrised, synchronous instruction memory for the 16-bit RISC core.
- Supports byte-addressed fetch with a one-cycle registered read, a fetch request/valid handshake and pipeline stall hold.
- Includes a serial program-load port that fills the array from address 0 without resynthesis.
- Flags fetches outside the array or at odd addresses and returns NOP_WORD for them.

Parameters:
- DATA_W, 16, instruction word width in bits.
- ADDR_W, 16, width of the byte-address PC.
- DEPTH, 16, number of instruction words. Must be a power of two, 2..2^(ADDR_W-1).
- NOP_WORD, 16'h0000, word returned on an errored fetch.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- fetch_req  in  1  fetch request, sampled when fetch_ready=1.
- fetch_pc  in  ADDR_W  byte address. Word index = fetch_pc[ADDR_W-1:1].
- fetch_ready  out  1  fetch accepted this cycle if fetch_req=1.
- stall  in  1  downstream hold.
- instr_valid  out  1  instr holds fetched word.
- instr  out  DATA_W  fetched instruction.
- addr_err  out  1  qualifies instr_valid: out-of-range or misaligned fetch.
- load_start  in  1  begin program load.
- load_valid  in  1  load_data is valid this cycle.
- load_data  in  DATA_W  word to write.
- load_busy  out  1  high while in LOAD.
- load_done  out  1  one-cycle pulse after the last word is written.

Behaviour:
- Reset (sync, rst=1 at a clk edge):
  - state=RUN, load counter=0.
  - instr_valid=0, instr=NOP_WORD, addr_err=0, load_busy=0, load_done=0.
  - Memory array is not cleared; contents are retained across reset.
- States: RUN, LOAD.
- fetch_ready = (state==RUN) && !stall. Combinational, no dependence on fetch_req.
- Fetch accept: fetch_req && fetch_ready at edge N gives instr_valid=1 after edge N+1 (latency 1).
  - Word index idx = fetch_pc[ADDR_W-1:1].
  - If fetch_pc[0]=1 or idx>=DEPTH: instr=NOP_WORD, addr_err=1.
  - Otherwise: instr=mem[idx], addr_err=0.
- Back-to-back fetches every cycle give full throughput, no bubbles.
- stall=1: instr, instr_valid and addr_err hold their values; no new fetch is accepted.
- No accepted fetch and stall=0: instr_valid=0 and addr_err=0 next cycle; instr holds its last value.
- RUN -> LOAD on load_start=1:
  - Counter cleared to 0; load_busy=1 from the next cycle.
  - A fetch accepted in the same cycle as load_start completes normally.
- In LOAD:
  - Each load_valid=1 writes mem[cnt]=load_data, then cnt++.
  - Gaps (load_valid=0) are allowed.
  - load_start is ignored.
  - fetch_ready=0.
  - instr_valid drops to 0 unless stall holds it.
- LOAD -> RUN when the write at cnt==DEPTH-1 occurs:
  - load_done=1 for exactly one cycle in the next cycle.
  - load_busy=0 in that same cycle.
  - cnt wraps to 0.
- Reset mid-load: return to RUN immediately. Words already written are kept, the remaining words are unchanged, and load_done is not pulsed.
- Read-during-write cannot occur, since fetch is blocked in LOAD.
- rst has priority over every other input.

Test Plan:
1. Reset, then load_start and 16 consecutive load_valid with data 16'h1000+i -> load_busy high 16 cycles; load_done pulses 1 cycle after the 16th write; fetch pc=0x0006 returns instr=16'h1003, addr_err=0, one cycle after accept.
2. Back-to-back fetches pc=0,2,4,...,30 on successive cycles -> instr_valid continuously 1 and instr=16'h1000..16'h100F in order; pc=0x0020 -> instr=16'h0000, addr_err=1.
3. Fetch pc=0x0003 (misaligned) -> instr=NOP_WORD, addr_err=1, instr_valid=1; the next idle cycle clears both.
4. Fetch pc=0x000A, then stall=1 for 3 cycles while fetch_req=1 with pc=0x000C -> fetch_ready=0 and instr=16'h1005 held for 3 cycles; on stall release, pc=0x000C is accepted and instr=16'h1006 follows.
5. Load with load_valid gaps (pattern 1,0,0,1,...) and load_start re-asserted mid-load -> writes land at consecutive addresses, re-start is ignored, load_done pulses once.
6. Load 16'hAAAA at addresses 0..4, assert rst, then fetch pc=0x0008 -> 16'hAAAA; fetch pc=0x000A -> previous content (16'h1005); load_done never pulses.
